// File: rtl/dm_mem_responder.sv
// rtl/dm_mem_responder.sv - line-sized main-memory responder for dm_cache_fsm
// Optional MEM_RAND_LATENCY_EN adds 0..3 LFSR-chosen latency cycles per transaction.
module dm_mem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [161:0] mem_req,
  output logic [128:0] mem_data,
  output logic         busy_o,
  output logic [15:0]  rd_count_o,
  output logic [15:0]  wr_count_o
);

  localparam int IDXW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t            state, state_nx;
  logic [8:0]        cnt, cnt_nx, accept_cnt;
  logic [IDXW-1:0]   hold_idx;
  logic [127:0]      hold_data;
  logic              hold_rw;
  logic              ready_q;
  logic [127:0]      data_q;
  logic [127:0]      rd_line;

  // mem_req_type = {addr, data, rw, valid}
  logic              req_valid, req_rw;
  logic [127:0]      req_data;
  logic [31:0]       req_addr;
  logic              unused_addr;

  assign req_valid   = mem_req[0];
  assign req_rw      = mem_req[1];
  assign req_data    = mem_req[129:2];
  assign req_addr    = mem_req[161:130];
  assign unused_addr = ^{req_addr[31:IDXW+4], req_addr[3:0]};

  // Lines never written read back their power-up pattern {4{i}}; contents survive reset.
  logic [127:0]         mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] written = '0;

  assign rd_line = written[hold_idx] ? mem[hold_idx] : {4{32'(hold_idx)}};

`ifdef MEM_RAND_LATENCY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      lfsr <= 8'hA5;
    else if (state == IDLE && req_valid)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign accept_cnt = 9'(LATENCY - 1) + {7'd0, lfsr[1:0]};
`else
  assign accept_cnt = 9'(LATENCY - 1);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        cnt_nx   = accept_cnt;
        state_nx = (accept_cnt == 9'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - 9'd1;
        if (cnt == 9'd1) state_nx = RESP;
      end
      RESP:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_o     <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      busy_o  <= (state_nx != IDLE);
      ready_q <= (state == RESP);
      if (state == RESP) begin
        data_q <= hold_rw ? hold_data : rd_line;
        if (hold_rw) begin
          if (wr_count_o != 16'hFFFF) wr_count_o <= wr_count_o + 16'd1;
        end else begin
          if (rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
        end
      end
    end
  end

  // Write commits on the ready edge, so a following read needs no bypass.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_valid) begin
      hold_idx  <= req_addr[IDXW+3:4];
      hold_data <= req_data;
      hold_rw   <= req_rw;
    end
    if (!reset_i && state == RESP && hold_rw) begin
      mem[hold_idx]     <= hold_data;
      written[hold_idx] <= 1'b1;
    end
  end

  assign mem_data = {data_q, ready_q};

endmodule
